// File: rtl/gcd_engine.sv
// Multi-cycle Euclidean GCD accelerator: start/busy/done handshake, abort,
// saturating iteration counter, zero-operand flag and a bit-serial modulo datapath.
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [CNT_W-1:0] steps_o,
   output logic             zero_err_o
);

   // state   | meaning
   // S_IDLE  | waiting for start_i
   // S_SORT  | order operands (x >= y), detect single zero, first remainder bit
   // S_MOD   | restoring remainder x mod y, one dividend bit per cycle
   // S_CHECK | count iteration; finish on zero remainder or swap and repeat
   // S_DONE  | one-cycle done pulse, result registered
   typedef enum logic [2:0] {S_IDLE, S_SORT, S_MOD, S_CHECK, S_DONE} state_t;

   localparam int BCW = $clog2(WIDTH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   state_t           r_state, w_state;
   logic [WIDTH-1:0] r_x, w_x;
   logic [WIDTH-1:0] r_y, w_y;
   logic [WIDTH:0]   r_r, w_r;
   logic [BCW-1:0]   r_bcnt, w_bcnt;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [WIDTH-1:0] r_result, w_result;
   logic [CNT_W-1:0] r_steps, w_steps;
   logic             r_zero_err, w_zero_err;
   logic             r_busy, w_busy;
   logic             r_done, w_done;

   logic [WIDTH-1:0] w_max, w_min;
   logic [WIDTH:0]   w_t, w_div, w_rem;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_max = (r_x >= r_y) ? r_x : r_y;
   assign w_min = (r_x >= r_y) ? r_y : r_x;

   // x is consumed as a left-shift register, so its MSB is always the next dividend bit.
   // SORT already handles bit 0 of the first division, keeping each iteration at WIDTH+1 cycles.
   assign w_t   = (r_state == S_SORT) ? {{WIDTH{1'b0}}, w_max[WIDTH-1]}
                                      : {r_r[WIDTH-1:0], r_x[WIDTH-1]};
   assign w_div = (r_state == S_SORT) ? {1'b0, w_min} : {1'b0, r_y};
   assign w_rem = (w_t >= w_div) ? (w_t - w_div) : w_t;

   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_state    = r_state;
      w_x        = r_x;
      w_y        = r_y;
      w_r        = r_r;
      w_bcnt     = r_bcnt;
      w_cnt      = r_cnt;
      w_result   = r_result;
      w_steps    = r_steps;
      w_zero_err = r_zero_err;

      case (r_state)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               w_x   = a_i;
               w_y   = b_i;
               w_cnt = '0;
               if ((a_i == '0) && (b_i == '0)) begin
                  w_state    = S_DONE;
                  w_result   = '0;
                  w_steps    = '0;
                  w_zero_err = 1'b1;
               end else begin
                  w_state = S_SORT;
               end
            end
         end
         S_SORT: begin
            if (w_min == '0) begin
               w_state    = S_DONE;
               w_result   = w_max;
               w_steps    = '0;
               w_zero_err = 1'b0;
            end else begin
               w_x     = {w_max[WIDTH-2:0], 1'b0};
               w_y     = w_min;
               w_r     = w_rem;
               w_bcnt  = BCW'(1);
               w_state = S_MOD;
            end
         end
         S_MOD: begin
            w_r = w_rem;
            w_x = {r_x[WIDTH-2:0], 1'b0};
            if (r_bcnt == LAST_BIT) begin
               w_state = S_CHECK;
            end else begin
               w_bcnt = r_bcnt + BCW'(1);
            end
         end
         S_CHECK: begin
            w_cnt = w_cnt_inc;
            if (r_r == '0) begin
               w_state    = S_DONE;
               w_result   = r_y;
               w_steps    = w_cnt_inc;
               w_zero_err = 1'b0;
            end else begin
               w_x     = r_y;
               w_y     = r_r[WIDTH-1:0];
               w_r     = '0;
               w_bcnt  = '0;
               w_state = S_MOD;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      // Abort drops the run without touching the previously reported result.
      if (abort_i && (r_state != S_IDLE)) begin
         w_state    = S_IDLE;
         w_result   = r_result;
         w_steps    = r_steps;
         w_zero_err = r_zero_err;
      end

      w_busy = (w_state == S_SORT) || (w_state == S_MOD) || (w_state == S_CHECK);
      w_done = (w_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_r        <= '0;
         r_bcnt     <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_steps    <= '0;
         r_zero_err <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_x        <= w_x;
         r_y        <= w_y;
         r_r        <= w_r;
         r_bcnt     <= w_bcnt;
         r_cnt      <= w_cnt;
         r_result   <= w_result;
         r_steps    <= w_steps;
         r_zero_err <= w_zero_err;
         r_busy     <= w_busy;
         r_done     <= w_done;
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign result_o   = r_result;
   assign steps_o    = r_steps;
   assign zero_err_o = r_zero_err;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: expected results from a plain Euclid model,
// checked by an independent monitor whenever done_o pulses.
module tb_gcd_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        start2_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [15:0] a_i = '0;
   logic [15:0] b_i = '0;

   logic        busy_o, done_o, zero_err_o;
   logic [15:0] result_o;
   logic [7:0]  steps_o;
   logic        busy2_o, done2_o, zero_err2_o;
   logic [15:0] result2_o;
   logic [1:0]  steps2_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int unsigned res;
      int unsigned steps;
      int unsigned zerr;
      int          lat;
      int          scyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int unsigned last_res = 0, last_steps = 0, last_zerr = 0;

   gcd_engine #(.WIDTH(16), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
      .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
      .result_o(result_o), .steps_o(steps_o), .zero_err_o(zero_err_o)
   );

   gcd_engine #(.WIDTH(16), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start_i(start2_i), .abort_i(abort_i),
      .a_i(a_i), .b_i(b_i), .busy_o(busy2_o), .done_o(done2_o),
      .result_o(result2_o), .steps_o(steps2_o), .zero_err_o(zero_err2_o)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Euclid on sorted operands; latency counts the start-sampling edge as edge 1.
   function automatic exp_t model(input int unsigned a, input int unsigned b, input int cw);
      exp_t        e;
      int unsigned x, y, t;
      int          k;
      k = 0;
      e.zerr = 0;
      if (a == 0 && b == 0) begin
         e.res = 0; e.zerr = 1; e.lat = 1;
      end else if (a == 0 || b == 0) begin
         e.res = a + b; e.lat = 2;
      end else begin
         x = (a > b) ? a : b;
         y = (a > b) ? b : a;
         while (y != 0) begin
            t = x % y; x = y; y = t; k++;
         end
         e.res = x;
         e.lat = 1 + k * 17;
      end
      e.steps = (k > (1 << cw) - 1) ? ((1 << cw) - 1) : k;
      e.scyc  = 0;
      return e;
   endfunction

   // which=0 -> main instance, which=1 -> CNT_W=2 instance; push=0 for runs that will be killed
   task automatic start_txn(input int unsigned a, input int unsigned b, input int which, input bit push);
      exp_t e;
      @(negedge clk);
      a_i = a[15:0];
      b_i = b[15:0];
      if (which == 0) start_i = 1'b1; else start2_i = 1'b1;
      if (push) begin
         e = model(a, b, (which == 0) ? 8 : 2);
         e.scyc = cyc + 1;
         if (which == 0) begin
            q1.push_back(e);
            last_res = e.res; last_steps = e.steps; last_zerr = e.zerr;
         end else begin
            q2.push_back(e);
         end
      end
      @(negedge clk);
      start_i  = 1'b0;
      start2_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (q1.size() != 0 || q2.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout: %0d results still pending after %0d cycles", q1.size() + q2.size(), budget);
         q1.delete();
         q2.delete();
      end
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done_o) begin
            if (q1.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done: got done with result %0d want no done", result_o);
            end else begin
               e = q1.pop_front();
               chk("result", 32'(result_o), e.res);
               chk("steps", 32'(steps_o), e.steps);
               chk("zero_err", 32'(zero_err_o), e.zerr);
               chk("latency", 32'(cyc - e.scyc + 1), 32'(e.lat));
            end
         end
         if (done2_o) begin
            if (q2.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done2: got done with result %0d want no done", result2_o);
            end else begin
               e = q2.pop_front();
               chk("result2", 32'(result2_o), e.res);
               chk("steps2", 32'(steps2_o), e.steps);
               chk("zero_err2", 32'(zero_err2_o), e.zerr);
               chk("latency2", 32'(cyc - e.scyc + 1), 32'(e.lat));
            end
         end
      end
   end

   initial begin : driver
      bit          busy_ok;
      int unsigned ra, rb;
      int unsigned sel;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_result", 32'(result_o), 0);
      chk("rst_steps", 32'(steps_o), 0);
      chk("rst_zero_err", 32'(zero_err_o), 0);
      rst = 1'b0;
      @(negedge clk);

      // 48/18 with busy held until the done edge
      start_txn(48, 18, 0, 1);
      busy_ok = 1'b1;
      for (int i = 0; i < 51; i++) begin
         if (!busy_o) busy_ok = 1'b0;
         @(negedge clk);
      end
      chk("busy_during_run", 32'(busy_ok), 1);
      wait_idle(100);

      start_txn(0, 35, 0, 1);     wait_idle(50);
      start_txn(0, 0, 0, 1);      wait_idle(50);
      start_txn(65535, 65534, 0, 1); wait_idle(100);
      start_txn(7, 7, 0, 1);      wait_idle(50);

      // abort on edge 10 of a run: no done, previous result held
      start_txn(48, 18, 0, 0);
      repeat (8) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      chk("abort_busy", 32'(busy_o), 0);
      chk("abort_result_held", 32'(result_o), last_res);
      chk("abort_steps_held", 32'(steps_o), last_steps);
      repeat (60) @(negedge clk);
      start_txn(17, 5, 0, 1);     wait_idle(100);

      // start pulse while busy is ignored
      start_txn(48, 18, 0, 1);
      repeat (5) @(negedge clk);
      a_i = 16'd9; b_i = 16'd3; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_idle(100);

      // synchronous reset in the middle of MOD
      start_txn(48, 18, 0, 0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(busy_o), 0);
      chk("midrst_done", 32'(done_o), 0);
      chk("midrst_result", 32'(result_o), 0);
      chk("midrst_steps", 32'(steps_o), 0);
      chk("midrst_zero_err", 32'(zero_err_o), 0);
      repeat (60) @(negedge clk);
      start_txn(100, 75, 0, 1);   wait_idle(100);

      // narrow counter saturates
      start_txn(89, 55, 1, 1);    wait_idle(300);
      start_txn(12, 8, 1, 1);     wait_idle(100);

      for (int i = 0; i < 24; i++) begin
         ra  = $urandom_range(0, 65535);
         rb  = $urandom_range(0, 65535);
         sel = $urandom_range(0, 7);
         case (sel)
            0: ra = 0;
            1: rb = 0;
            2: rb = ra;
            3: begin ra = $urandom_range(1, 60); rb = $urandom_range(1, 60); end
            4: rb = 65535;
            default: ;
         endcase
         start_txn(ra, rb, (i % 4 == 3) ? 1 : 0, 1);
         wait_idle(1000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
